cruzamento_ctrl: RTL and testbench

//  Intersection scheduler. Shares one crossing between main road A and side road B.

---
 rtl/cruzamento_ctrl.sv | 100 ++++++++++
 tb/tb_cruzamento_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cruzamento_ctrl.sv
// Intersection scheduler: sequences main road A and side road B through timed
// green/yellow/all-red phases, latching side-road and pedestrian requests.
module cruzamento_ctrl #(
  parameter int unsigned CW          = 8,
  parameter int unsigned T_GREEN_MIN = 8,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 2,
  parameter int unsigned T_SIDE_MAX  = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       CAR_B,
  input  logic       PED,
  output logic       GRN_A,
  output logic       YLW_A,
  output logic       RED_A,
  output logic       GRN_B,
  output logic       YLW_B,
  output logic       RED_B,
  output logic       WALK,
  output logic [2:0] phase,
  output logic       req
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YLW = 3'd1,
    AR1   = 3'd2,
    B_GRN = 3'd3,
    B_YLW = 3'd4,
    AR2   = 3'd5
  } state_t;

  localparam logic [CW-1:0] GMIN_LAST = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] YLW_LAST  = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] SIDE_LAST = CW'(T_SIDE_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          enter_b;

  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN: if ((cnt >= GMIN_LAST) && (req || CAR_B)) state_nxt = A_YLW;
      A_YLW: if (cnt == YLW_LAST) state_nxt = AR1;
      AR1:   if (cnt == AR_LAST) state_nxt = B_GRN;
      B_GRN: if ((cnt == SIDE_LAST) || ((cnt >= GMIN_LAST) && !CAR_B))
               state_nxt = B_YLW;
      B_YLW: if (cnt == YLW_LAST) state_nxt = AR2;
      AR2:   if (cnt == AR_LAST) state_nxt = A_GRN;
      default: state_nxt = A_GRN;
    endcase
  end

  assign enter_b = (state_nxt == B_GRN) && (state != B_GRN);

  // Clearing req on B_GRN entry takes priority over a request seen on that same edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= A_GRN;
      cnt   <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      if (enter_b)
        req <= 1'b0;
      else if ((state != B_GRN) && (PED || CAR_B))
        req <= 1'b1;
    end
  end

  always_comb begin
    GRN_A = 1'b0;
    YLW_A = 1'b0;
    RED_A = 1'b0;
    GRN_B = 1'b0;
    YLW_B = 1'b0;
    RED_B = 1'b0;
    WALK  = 1'b0;
    case (state)
      A_GRN: begin GRN_A = 1'b1; RED_B = 1'b1; end
      A_YLW: begin YLW_A = 1'b1; RED_B = 1'b1; end
      AR1, AR2: begin RED_A = 1'b1; RED_B = 1'b1; end
      B_GRN: begin RED_A = 1'b1; GRN_B = 1'b1; WALK = 1'b1; end
      B_YLW: begin RED_A = 1'b1; YLW_B = 1'b1; end
      default: begin GRN_A = 1'b1; RED_B = 1'b1; end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_cruzamento_ctrl.sv
// Bench for cruzamento_ctrl: cycle model feeds a scoreboard of expected outputs,
// plus directed dwell, reset and request-latch scenarios and a random soak.
module tb_cruzamento_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       CAR_B = 1'b0;
  logic       PED = 1'b0;
  logic       GRN_A, YLW_A, RED_A, GRN_B, YLW_B, RED_B, WALK, req;
  logic [2:0] phase;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  int m_state, m_cnt, run;
  bit m_req;
  logic [10:0] sb[$];

  cruzamento_ctrl #(.CW(8), .T_GREEN_MIN(8), .T_YELLOW(3), .T_ALLRED(2), .T_SIDE_MAX(10)) dut (
    .clk(clk), .res(res), .CAR_B(CAR_B), .PED(PED),
    .GRN_A(GRN_A), .YLW_A(YLW_A), .RED_A(RED_A),
    .GRN_B(GRN_B), .YLW_B(YLW_B), .RED_B(RED_B),
    .WALK(WALK), .phase(phase), .req(req)
  );

  always #5 clk = ~clk;

  assign obs = {GRN_A, YLW_A, RED_A, GRN_B, YLW_B, RED_B, WALK, phase, req};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Light order: GRN_A YLW_A RED_A GRN_B YLW_B RED_B WALK
  function automatic logic [10:0] pack(input int st, input bit rq);
    logic [6:0] l;
    case (st)
      0: l = 7'b1000010;
      1: l = 7'b0100010;
      2, 5: l = 7'b0010010;
      3: l = 7'b0011001;
      4: l = 7'b0010100;
      default: l = 7'b0000000;
    endcase
    return {l, 3'(st), rq};
  endfunction

  task automatic model_edge();
    int ns;
    ns = m_state;
    if (m_state == 0 && m_cnt >= 7 && (m_req || CAR_B)) ns = 1;
    if (m_state == 1 && m_cnt == 2) ns = 2;
    if (m_state == 2 && m_cnt == 1) ns = 3;
    if (m_state == 3 && (m_cnt == 9 || (m_cnt >= 7 && !CAR_B))) ns = 4;
    if (m_state == 4 && m_cnt == 2) ns = 5;
    if (m_state == 5 && m_cnt == 1) ns = 0;
    if (ns == 3 && m_state != 3) m_req = 1'b0;
    else if (m_state != 3 && (PED || CAR_B)) m_req = 1'b1;
    if (ns != m_state) m_cnt = 0;
    else if (m_cnt < 255) m_cnt = m_cnt + 1;
    m_state = ns;
  endtask

  task automatic check_dwell(input int ph, input int n);
    case (ph)
      0: chk("dwell_agrn", n >= 8, 1);
      3: chk("dwell_bgrn", n >= 8 && n <= 10, 1);
      1, 4: chk("dwell_ylw", n, 3);
      default: chk("dwell_allred", n, 2);
    endcase
  endtask

  task automatic step();
    logic [10:0] e;
    int pre;
    pre = int'(phase);
    model_edge();
    sb.push_back(pack(m_state, m_req));
    run++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("outs", obs, e);
    chk("one_light_a", int'(GRN_A) + int'(YLW_A) + int'(RED_A), 1);
    chk("one_light_b", int'(GRN_B) + int'(YLW_B) + int'(RED_B), 1);
    chk("conflict", (GRN_A | YLW_A) & (GRN_B | YLW_B), 0);
    chk("walk_only_bgrn", WALK, phase == 3'd3);
    chk("phase_legal", phase < 3'd6, 1);
    if (int'(phase) != pre) begin
      check_dwell(pre, run);
      run = 0;
    end
  endtask

  task automatic do_reset();
    res = 1'b0;
    #2;
    chk("rst_outs", obs, 11'b10000100000);
    m_state = 0; m_cnt = 0; m_req = 1'b0; run = 0;
    sb.delete();
    #1 res = 1'b1;
  endtask

  task automatic meas(input int ph, output int n);
    n = 0;
    while (int'(phase) == ph && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic until_model(input int st, input int c);
    int k = 0;
    while (!(m_state == st && (c < 0 || m_cnt == c)) && k < 200) begin
      step();
      k++;
    end
    chk("reach_phase", int'(phase), st);
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset();

    // Car waiting continuously: full cycle with B green capped at max.
    CAR_B = 1'b1;
    meas(0, n); chk("t1_agrn", n, 8);
    meas(1, n); chk("t1_aylw", n, 3);
    meas(2, n); chk("t1_ar1", n, 2);
    meas(3, n); chk("t1_bgrn_cap", n, 10);
    meas(4, n); chk("t1_bylw", n, 3);
    meas(5, n); chk("t1_ar2", n, 2);
    chk("t1_back_agrn", phase, 3'd0);

    // Single pedestrian pulse on cycle 3.
    CAR_B = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    PED = 1'b1; step(); PED = 1'b0;
    chk("t2_req_set", req, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (WALK) n++;
    end
    chk("t2_walk_len", n, 8);

    // Idle: counter saturates, then a car triggers yellow on the next edge.
    do_reset();
    for (int i = 0; i < 300; i++) step();
    chk("t3_cnt_sat", 32'(dut.cnt), 255);
    chk("t3_still_agrn", phase, 3'd0);
    CAR_B = 1'b1; step();
    chk("t3_to_aylw", phase, 3'd1);

    // Asynchronous reset in the middle of B green.
    until_model(3, 4);
    do_reset();
    chk("t4_req_clr", req, 1'b0);
    meas(0, n); chk("t4_agrn_full", n, 8);

    // Request on the last all-red cycle is lost to the B-entry clear;
    // request during B yellow is kept and served after exactly 8 cycles of A.
    do_reset();
    until_model(2, 1);
    CAR_B = 1'b0; PED = 1'b1; step(); PED = 1'b0;
    chk("t5_bgrn", phase, 3'd3);
    chk("t5_req_clr", req, 1'b0);
    until_model(4, -1);
    PED = 1'b1; step(); PED = 1'b0;
    chk("t5_req_ylw", req, 1'b1);
    until_model(0, -1);
    meas(0, n); chk("t5_agrn_len", n, 8);
    chk("t5_aylw", phase, 3'd1);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      CAR_B = ($urandom_range(0, 3) == 0);
      PED   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
